// File: rtl/md_unit_pkg.sv
// Shared constants and types for the EX-stage multiply/divide unit:
// SPECIAL opcode, MD funct codes and default latencies.
package md_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // One-hot decode of the MD-class instruction currently in EX.
    typedef struct packed {
        logic mult;
        logic multu;
        logic div;
        logic divu;
        logic mfhi;
        logic mflo;
        logic mthi;
        logic mtlo;
    } md_op_t;

endpackage

// File: rtl/md_decode.sv
// Combinational MD-class decoder: instruction word -> one-hot md_op_t.
// Kept standalone so the hazard unit can reuse it.
module md_decode
    import md_unit_pkg::*;
(
    input  logic [31:0] instr,
    output md_op_t      op
);

    always_comb begin
        op = '0;
        if (instr[31:26] == OP_SPECIAL) begin
            case (instr[5:0])
                F_MULT:  op.mult  = 1'b1;
                F_MULTU: op.multu = 1'b1;
                F_DIV:   op.div   = 1'b1;
                F_DIVU:  op.divu  = 1'b1;
                F_MFHI:  op.mfhi  = 1'b1;
                F_MFLO:  op.mflo  = 1'b1;
                F_MTHI:  op.mthi  = 1'b1;
                F_MTLO:  op.mtlo  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO. Result is computed at start,
// held in pending regs, and committed after a fixed busy window.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrE,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] mdresult,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_op_t             op;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi, pend_lo;
    logic               pend_wr;

    logic               is_div, div_zero;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        a_mag, b_mag, a_div, b_div, q_raw, r_raw, q_s, r_s;
    logic [31:0]        res_hi, res_lo;

    md_decode u_dec (
        .instr (instrE),
        .op    (op)
    );

    assign is_div   = op.div | op.divu;
    assign start    = (op.mult | op.multu | is_div) & ~busy;
    assign mdresult = op.mfhi ? hi : lo;

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes avoids the -2^31 / -1 overflow corner;
    // the divisor is forced to 1 on B==0 only to keep the datapath defined.
    assign div_zero = (B == 32'd0);
    assign a_mag    = A[31] ? -A : A;
    assign b_mag    = B[31] ? -B : B;
    assign a_div    = op.div ? a_mag : A;
    assign b_div    = div_zero ? 32'd1 : (op.div ? b_mag : B);
    assign q_raw    = a_div / b_div;
    assign r_raw    = a_div % b_div;
    assign q_s      = (A[31] ^ B[31]) ? -q_raw : q_raw;
    assign r_s      = A[31] ? -r_raw : r_raw;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (op.mult) begin
            {res_hi, res_lo} = prod_s;
        end else if (op.multu) begin
            {res_hi, res_lo} = prod_u;
        end else if (op.div) begin
            res_hi = r_s;
            res_lo = q_s;
        end else if (op.divu) begin
            res_hi = r_raw;
            res_lo = q_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= ~(is_div & div_zero);
            cnt     <= is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            busy    <= 1'b1;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end else begin
            if (op.mthi) hi <= A;
            if (op.mtlo) lo <= A;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random MD
// traffic against an arithmetic HI/LO reference model.
module tb_md_unit;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrE, A, B;
    logic [31:0] mdresult, hi, lo;
    logic        start, busy;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    md_unit #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .instrE   (instrE),
        .A        (A),
        .B        (B),
        .mdresult (mdresult),
        .start    (start),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc(input logic [5:0] funct);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'b000000, mid, funct};
    endfunction

    function automatic logic [31:0] nop_instr();
        logic [25:0] rest;
        rest = 26'($urandom);
        return {6'b100011, rest};
    endfunction

    // Traffic that must have no effect while the unit is busy.
    function automatic logic [31:0] noise_instr();
        case ($urandom_range(0, 5))
            0: return enc(6'h18);
            1: return enc(6'h1A);
            2: return enc(6'h11);
            3: return enc(6'h13);
            4: return enc(6'h10);
            default: return nop_instr();
        endcase
    endfunction

    task automatic do_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          n;
        bit          wr;
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        wr = 1'b1;
        p  = '0;
        n  = MULT_CYC;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'h18: p = 64'(sa * sb);
            6'h19: p = 64'({32'd0, a}) * 64'({32'd0, b});
            6'h1A: begin
                n = DIV_CYC;
                if (b == 0) wr = 1'b0;
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = {32'(sr), 32'(sq)};
                end
            end
            default: begin
                n = DIV_CYC;
                if (b == 0) wr = 1'b0;
                else p = {a % b, a / b};
            end
        endcase
        @(negedge clk);
        instrE = enc(f); A = a; B = b;
        #1 check({tag, " start"}, 32'(start), 32'd1);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            instrE = noise_instr(); A = $urandom; B = $urandom;
            #1;
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " start while busy"}, 32'(start), 32'd0);
            check({tag, " hi held"}, hi, m_hi);
            check({tag, " lo held"}, lo, m_lo);
        end
        @(negedge clk);
        instrE = nop_instr();
        if (wr) begin
            m_hi = p[63:32];
            m_lo = p[31:0];
        end
        #1;
        check({tag, " busy done"}, 32'(busy), 32'd0);
        check({tag, " hi"}, hi, m_hi);
        check({tag, " lo"}, lo, m_lo);
    endtask

    task automatic do_mt(input bit to_hi, input logic [31:0] a);
        @(negedge clk);
        instrE = enc(to_hi ? 6'h11 : 6'h13); A = a;
        #1 check("mt start", 32'(start), 32'd0);
        if (to_hi) m_hi = a; else m_lo = a;
        @(negedge clk);
        instrE = nop_instr();
        #1;
        check("mt hi", hi, m_hi);
        check("mt lo", lo, m_lo);
        check("nop mdresult", mdresult, m_lo);
    endtask

    task automatic do_mf(input bit from_hi);
        @(negedge clk);
        instrE = enc(from_hi ? 6'h10 : 6'h12); A = $urandom;
        #1 check(from_hi ? "mfhi" : "mflo", mdresult, from_hi ? m_hi : m_lo);
    endtask

    initial begin
        reset = 1'b1; instrE = nop_instr(); A = '0; B = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst start", 32'(start), 32'd0);
        reset = 1'b0;

        // Non-SPECIAL opcode with a mult funct must not start.
        @(negedge clk);
        instrE = {6'b000001, 20'h12345, 6'h18};
        #1 check("decode opcode", 32'(start), 32'd0);

        do_md(6'h18, 32'hFFFFFFFE, 32'd3, "mult");
        do_mf(1'b0);
        do_mf(1'b1);
        do_md(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
        do_md(6'h1A, 32'hFFFFFFF9, 32'd2, "div");
        do_md(6'h1B, 32'hFFFFFFF9, 32'd2, "divu");
        do_md(6'h1A, 32'h80000000, 32'hFFFFFFFF, "div ovf");
        do_mt(1'b1, 32'h11);
        do_mt(1'b0, 32'h22);
        do_md(6'h1A, 32'h12345678, 32'd0, "div0");
        do_mt(1'b1, 32'hDEADBEEF);
        do_mf(1'b1);

        // Reset four cycles into a divide: nothing may commit afterwards.
        @(negedge clk);
        instrE = enc(6'h1A); A = 32'd100; B = 32'd7;
        repeat (4) begin
            @(negedge clk);
            instrE = nop_instr();
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; m_hi = '0; m_lo = '0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        repeat (DIV_CYC + 2) @(negedge clk);
        #1;
        check("midrst no commit hi", hi, 32'd0);
        check("midrst no commit lo", lo, 32'd0);
        check("midrst idle", 32'(busy), 32'd0);
        do_md(6'h18, 32'h00001234, 32'hFFFF0001, "post-rst mult");

        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            if ($urandom_range(0, 7) == 0) rb = '0;
            case ($urandom_range(0, 7))
                0: do_md(6'h18, ra, rb, "rnd mult");
                1: do_md(6'h19, ra, rb, "rnd multu");
                2: do_md(6'h1A, ra, rb, "rnd div");
                3: do_md(6'h1B, ra, rb, "rnd divu");
                4: do_mt(1'b1, ra);
                5: do_mt(1'b0, ra);
                6: do_mf(1'b1);
                default: do_mf(1'b0);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
